// File: rtl/uart_frame_if.sv
// Byte-stream in, frame-RAM write port and frame status out.
interface uart_frame_if;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic       buf_sel;
    logic       busy;

    modport master (
        output byte_valid, rx_byte,
        input  wr_en, wr_addr, wr_data,
        input  frame_done, frame_err, buf_sel, busy
    );

    modport slave (
        input  byte_valid, rx_byte,
        output wr_en, wr_addr, wr_data,
        output frame_done, frame_err, buf_sel, busy
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame receiver: header, payload, checksum; double-buffered
// frame RAM writes with inter-byte timeout.
module uart_frame_ctrl #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         FRAME_BYTES = 64,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic         clk_100M,
    input  logic         rst,
    uart_frame_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [5:0] IDX_LAST = 6'(FRAME_BYTES - 1);

    logic [1:0]    state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] to_q, to_d;
    logic          buf_q, buf_d;
    logic          wr_en_q, wr_en_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        to_d    = to_q;
        buf_d   = buf_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                to_d = '0;
                if (bus.byte_valid && bus.rx_byte == HEADER) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            S_DATA: begin
                // A HEADER value here is ordinary payload.
                if (bus.byte_valid) begin
                    to_d    = '0;
                    wr_en_d = 1'b1;
                    addr_d  = {~buf_q, idx_q};
                    data_d  = bus.rx_byte;
                    idx_d   = idx_q + 6'd1;
                    sum_d   = sum_q + bus.rx_byte;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_CHECK;
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_ONE;
                end
            end
            S_CHECK: begin
                if (bus.byte_valid) begin
                    to_d    = '0;
                    state_d = S_IDLE;
                    if (bus.rx_byte == sum_q) begin
                        done_d = 1'b1;
                        buf_d  = ~buf_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            to_q    <= '0;
            buf_q   <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            to_q    <= to_d;
            buf_q   <= buf_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.buf_sel    = buf_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: frame-level reference model compared
// every cycle, directed scenarios plus randomized frames.
module tb_uart_frame_ctrl;
    localparam int T = 200;
    localparam int N = 64;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk_100M = 1'b0;
    logic rst = 1'b1;
    always #5 clk_100M = ~clk_100M;

    uart_frame_if bus();

    uart_frame_ctrl #(
        .HEADER(HDR), .FRAME_BYTES(N), .TIMEOUT_CYC(T)
    ) dut (
        .clk_100M(clk_100M),
        .rst(rst),
        .bus(bus)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;

    // Reference model: frame position, received payload, idle gap.
    int         m_pos = -1;
    logic [7:0] m_pl[$];
    int         m_gap = 0;
    logic       m_buf = 1'b0;

    logic       e_wr = 0, e_done = 0, e_err = 0;
    logic       e_busy = 0, e_buf = 0, e_rst = 1;
    logic [6:0] e_addr = 0;
    logic [7:0] e_data = 0;
    logic       chk_on = 0;

    int n_wr = 0, n_done = 0, n_ferr = 0;
    int err_cyc = -1, last_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] psum();
        int s = 0;
        foreach (m_pl[i]) s += int'(m_pl[i]);
        return 8'(s & 255);
    endfunction

    task automatic model(input logic r, input logic bv,
                         input logic [7:0] b);
        e_wr = 0; e_done = 0; e_err = 0; e_rst = r;
        if (r) begin
            m_pos = -1; m_buf = 0; m_gap = 0;
            e_addr = 0; e_data = 0;
        end else if (m_pos < 0) begin
            if (bv && b == HDR) begin
                m_pos = 0; m_gap = 0; m_pl.delete();
            end
        end else if (bv) begin
            m_gap = 0;
            if (m_pos < N) begin
                e_wr = 1;
                e_addr = 7'((m_buf ? 0 : N) + m_pos);
                e_data = b;
                m_pl.push_back(b);
                m_pos++;
            end else begin
                if (b == psum()) begin
                    e_done = 1; m_buf = ~m_buf;
                end else begin
                    e_err = 1;
                end
                m_pos = -1;
            end
        end else begin
            m_gap++;
            if (m_gap == T) begin
                e_err = 1; m_pos = -1;
            end
        end
        e_buf = m_buf;
        e_busy = (m_pos >= 0);
    endtask

    task automatic step(input logic r, input logic bv,
                        input logic [7:0] b);
        rst = r;
        bus.byte_valid = bv;
        bus.rx_byte = bv ? b : 8'($urandom);
        @(posedge clk_100M);
        cyc++;
        model(r, bv, b);
        if (bv && !r) last_cyc = cyc;
        @(negedge clk_100M);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat ($urandom_range(0, gap)) step(0, 0, 8'h00);
        step(0, 1, b);
    endtask

    task automatic send_frame(input logic [7:0] pl[N],
                              input logic [7:0] ck, input int gap);
        send_byte(HDR, gap);
        for (int i = 0; i < N; i++) send_byte(pl[i], gap);
        send_byte(ck, gap);
    endtask

    function automatic logic [7:0] sum_of(input logic [7:0] pl[N]);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(pl[i]);
        return 8'(s & 255);
    endfunction

    always @(negedge clk_100M) begin
        if (chk_on) begin
            chk("wr_en", int'(bus.wr_en), int'(e_wr));
            chk("frame_done", int'(bus.frame_done), int'(e_done));
            chk("frame_err", int'(bus.frame_err), int'(e_err));
            chk("busy", int'(bus.busy), int'(e_busy));
            chk("buf_sel", int'(bus.buf_sel), int'(e_buf));
            if (e_wr || e_rst) begin
                chk("wr_addr", int'(bus.wr_addr), int'(e_addr));
                chk("wr_data", int'(bus.wr_data), int'(e_data));
            end
            if (bus.wr_en) n_wr++;
            if (bus.frame_done) n_done++;
            if (bus.frame_err) begin
                n_ferr++;
                err_cyc = cyc;
            end
        end
    end

    initial begin
        logic [7:0] pl[N];
        logic [7:0] ck;
        int w0, d0, f0, mode;
        bus.byte_valid = 0;
        bus.rx_byte = 0;
        step(1, 0, 8'h00);
        chk_on = 1;
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        chk("rst_buf_sel", int'(bus.buf_sel), 0);
        chk("rst_busy", int'(bus.busy), 0);

        // Counting payload 00..3F
        for (int i = 0; i < N; i++) pl[i] = 8'(i);
        w0 = n_wr; d0 = n_done;
        send_frame(pl, 8'hE0, 0);
        step(0, 0, 8'h00);
        chk("f1_model_sum", int'(psum()), 'hE0);
        chk("f1_writes", n_wr - w0, 64);
        chk("f1_done", n_done - d0, 1);
        chk("f1_buf_sel", int'(bus.buf_sel), 1);

        // All-FF payload into the other buffer
        for (int i = 0; i < N; i++) pl[i] = 8'hFF;
        w0 = n_wr; d0 = n_done;
        send_frame(pl, 8'hC0, 1);
        step(0, 0, 8'h00);
        chk("f2_model_sum", int'(psum()), 'hC0);
        chk("f2_writes", n_wr - w0, 64);
        chk("f2_buf_sel", int'(bus.buf_sel), 0);

        // Wrong checksum
        for (int i = 0; i < N; i++) pl[i] = 8'(i);
        d0 = n_done; f0 = n_ferr;
        send_frame(pl, 8'h00, 0);
        step(0, 0, 8'h00);
        chk("bad_ck_err", n_ferr - f0, 1);
        chk("bad_ck_done", n_done - d0, 0);
        chk("bad_ck_buf", int'(bus.buf_sel), 0);
        chk("bad_ck_idle", int'(bus.busy), 0);

        // Timeout after 10 payload bytes
        f0 = n_ferr;
        send_byte(HDR, 0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        repeat (T + 5) step(0, 0, 8'h00);
        chk("to_err", n_ferr - f0, 1);
        chk("to_latency", err_cyc - last_cyc, T);
        d0 = n_done;
        send_frame(pl, 8'hE0, 0);
        step(0, 0, 8'h00);
        chk("to_recover", n_done - d0, 1);

        // Byte arriving on the would-be expiry cycle is kept
        f0 = n_ferr; d0 = n_done;
        send_byte(HDR, 0);
        send_byte(pl[0], 0);
        repeat (T - 1) step(0, 0, 8'h00);
        for (int i = 1; i < N; i++) send_byte(pl[i], 0);
        send_byte(8'hE0, 0);
        step(0, 0, 8'h00);
        chk("expiry_tie_done", n_done - d0, 1);
        chk("expiry_tie_noerr", n_ferr - f0, 0);

        // Junk in IDLE
        w0 = n_wr;
        send_byte(8'h00, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hFF, 0);
        step(0, 0, 8'h00);
        chk("idle_junk_wr", n_wr - w0, 0);
        chk("idle_junk_busy", int'(bus.busy), 0);

        // Reset mid-frame with buf_sel = 1
        if (m_buf == 0) send_frame(pl, 8'hE0, 0);
        f0 = n_ferr;
        send_byte(HDR, 0);
        for (int i = 0; i < 30; i++) send_byte(pl[i], 0);
        step(1, 0, 8'h00);
        w0 = n_wr;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("mid_rst_buf", int'(bus.buf_sel), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_noerr", n_ferr - f0, 0);
        chk("mid_rst_nowr", n_wr - w0, 0);
        d0 = n_done;
        send_frame(pl, 8'hE0, 0);
        step(0, 0, 8'h00);
        chk("post_rst_done", n_done - d0, 1);

        // HEADER value inside the payload
        for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
        pl[5] = HDR;
        d0 = n_done;
        send_frame(pl, sum_of(pl), 1);
        step(0, 0, 8'h00);
        chk("hdr_in_payload", n_done - d0, 1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 9);
            for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
            ck = sum_of(pl);
            if (mode <= 4) begin
                send_frame(pl, ck, 3);
            end else if (mode == 5) begin
                send_frame(pl, ck ^ 8'($urandom_range(1, 255)), 2);
            end else if (mode == 6) begin
                send_byte(HDR, 1);
                for (int i = 0; i < $urandom_range(0, N); i++)
                    send_byte(pl[i], 1);
                repeat (T + $urandom_range(0, 3)) step(0, 0, 8'h00);
            end else if (mode == 7) begin
                send_byte(HDR, 1);
                for (int i = 0; i < $urandom_range(0, N); i++)
                    send_byte(pl[i], 1);
                step(1, 0, 8'h00);
            end else begin
                for (int i = 0; i < 4; i++) send_byte(8'($urandom), 2);
            end
        end
        repeat (T + 2) step(0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter HEADER, default 8'hA5, start-of-frame marker byte.
REQ-002 Parameter FRAME_BYTES, default 64, payload bytes per frame (8x8x8 cube, 1 bit per LED).
REQ-003 Parameter TIMEOUT_CYC, default 100000, maximum idle clocks between bytes inside a frame (1 ms at 100 MHz).
REQ-004 clk_100M  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 byte_valid  input  1  one-cycle strobe; byte holds a received UART byte.
REQ-007 byte  input  8  received byte, sampled only when byte_valid=1.
REQ-008 wr_en  output  1  frame-RAM write strobe, one cycle per payload byte.
REQ-009 wr_addr  output  7  write address {back-buffer bit, payload index[5:0]}.
REQ-010 wr_data  output  8  payload byte to write.
REQ-011 frame_done  output  1  one-cycle pulse: frame received with correct checksum.
REQ-012 frame_err  output  1  one-cycle pulse: frame aborted (checksum mismatch or timeout).
REQ-013 buf_sel  output  1  buffer index the display reads; writes always target ~buf_sel.
REQ-014 busy  output  1  high while a frame is in progress (state DATA or CHECK).

Function
REQ-015 Wire format: HEADER, then FRAME_BYTES payload bytes, then one checksum byte equal to the mod-256 sum of the payload bytes.
REQ-016 FSM states: IDLE, DATA, CHECK; all outputs are registered.
REQ-017 In IDLE, byte_valid with byte==HEADER moves to DATA and clears the index and checksum accumulator; any other byte is ignored with no output activity.
REQ-018 In DATA, each byte_valid produces wr_en=1 on the next cycle, with wr_data=byte and wr_addr={~buf_sel, index}; the index then increments and the accumulator adds byte (8-bit wrap).
REQ-019 In DATA, a byte equal to HEADER is payload, not a resynchronisation.
REQ-020 After the FRAME_BYTES-th payload byte (index 63), the FSM moves to CHECK; the index never wraps into a second frame.
REQ-021 In CHECK, byte_valid with byte==accumulator: frame_done=1 on the next cycle, buf_sel toggles on that same edge, FSM returns to IDLE.
REQ-022 In CHECK, byte_valid with byte!=accumulator: frame_err=1 on the next cycle, buf_sel unchanged, FSM returns to IDLE.
REQ-023 Timeout counter clears on entry to DATA and on every byte_valid, and counts every other clock in DATA/CHECK; on reaching TIMEOUT_CYC-1 it raises frame_err on the next cycle and returns to IDLE.
REQ-024 When byte_valid and timeout expiry coincide, the byte is processed and the timeout is discarded.
REQ-025 An aborted frame leaves partial data in the back buffer only; the display buffer is never written.
REQ-026 wr_en, frame_done and frame_err are each high for at most one cycle per byte_valid and are never high simultaneously.
REQ-027 busy=1 exactly while the state is DATA or CHECK.

Reset
REQ-028 rst=1 at a clock edge forces IDLE, buf_sel=0, and wr_en=frame_done=frame_err=busy=0, with wr_addr=0, wr_data=0, counters and accumulator cleared.
REQ-029 rst asserted mid-frame discards the frame with no frame_err pulse and no further writes.

Verification
REQ-030 Send A5, payload 00..3F, checksum 8'hE0 -> 64 wr_en pulses at addr 64..127 carrying data 00..3F; frame_done pulse; buf_sel 0->1.
REQ-031 Second good frame (payload all 8'hFF, checksum 8'hC0) -> writes to addr 0..63; buf_sel 1->0.
REQ-032 Good payload with wrong checksum 8'h00 -> frame_err pulse, no frame_done, buf_sel unchanged, FSM in IDLE.
REQ-033 Stop after 10 payload bytes -> frame_err exactly TIMEOUT_CYC cycles after the last byte_valid; a following valid frame completes normally.
REQ-034 Bytes 00, 5A, FF in IDLE -> no output activity; payload containing A5 at index 5 -> written as data, frame completes.
REQ-035 rst pulsed after the 30th payload byte -> buf_sel=0, busy=0, no pulses; a subsequent full frame completes normally.
